// File: rtl/shift_pkg.sv
// shift_pkg: operation encoding, flag bit indices and shift-amount width helper
package shift_pkg;
  typedef enum logic [2:0] {
    NOP = 3'd0,
    LSL = 3'd1,
    LSR = 3'd2,
    ASR = 3'd3,
    ROR = 3'd4,
    ROL = 3'd5
  } shift_op_e;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;
  function automatic int shw_of(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/shift_level.sv
// shift_level: one barrel level moving data by DIST bit positions when enabled
module shift_level
  import shift_pkg::*;
#(
  parameter int W    = 32,
  parameter int DIST = 1
) (
  input  logic [W-1:0] data,
  input  shift_op_e    op,
  input  logic         en,
  output logic [W-1:0] q
);
  logic [W-1:0] s;
  assign s = op == LSL ? data << DIST :
             op == LSR ? data >> DIST :
             op == ASR ? $unsigned($signed(data) >>> DIST) :
             op == ROR ? {data[DIST-1:0], data[W-1:DIST]} :
             op == ROL ? {data[W-DIST-1:0], data[W-1:W-DIST]} : data;
  assign q = en ? s : data;
endmodule

// File: rtl/pipelined_shift_unit.sv
// pipelined_shift_unit: barrel shifter/rotator split over STAGES registered stages with valid/ready
module pipelined_shift_unit
  import shift_pkg::*;
#(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  shift_op_e    in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [1:0]   out_flag
);
  localparam int SHW = shw_of(W);
  logic           stall;
  logic           c0;
  logic           r_z;
  logic           unused_ok;
  logic [SHW-1:0] sh0, il, ir;
  logic [W-1:0]   lin [SHW];
  logic [W-1:0]   lout [SHW];
  logic [W-1:0]   st [STAGES];
  logic [W-1:0]   r_d [STAGES];
  shift_op_e      s_op [STAGES];
  shift_op_e      r_op [STAGES];
  logic [SHW-1:0] s_sh [STAGES];
  logic [SHW-1:0] r_sh [STAGES];
  logic           s_c [STAGES];
  logic           r_c [STAGES];
  logic           s_v [STAGES];
  logic           r_v [STAGES];
  assign sh0 = in_b[SHW-1:0];
  assign il = -sh0;
  assign ir = sh0 - SHW'(1);
  assign c0 = sh0 == '0 ? 1'b0 :
              (in_op == LSL || in_op == ROL) ? in_a[il] :
              (in_op == LSR || in_op == ASR || in_op == ROR) ? in_a[ir] : 1'b0;
  assign stall = out_valid && !out_ready;
  assign in_ready = !stall;
  assign out_valid = r_v[STAGES-1];
  assign out_result = r_d[STAGES-1];
  assign out_flag[FLAG_C] = r_c[STAGES-1];
  assign out_flag[FLAG_Z] = r_z;
  assign unused_ok = ^{in_b, r_sh[STAGES-1], r_op[STAGES-1]};
  for (genvar j = 0; j < STAGES; j++) begin : g_src
    if (j == 0) begin : g_in
      assign s_op[j] = in_op;
      assign s_sh[j] = sh0;
      assign s_c[j] = c0;
      assign s_v[j] = in_valid;
    end else begin : g_reg
      assign s_op[j] = r_op[j-1];
      assign s_sh[j] = r_sh[j-1];
      assign s_c[j] = r_c[j-1];
      assign s_v[j] = r_v[j-1];
    end
  end
  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    localparam int S = k * STAGES / SHW;
    if (k == 0) begin : g_first
      assign lin[k] = in_a;
    end else if ((k - 1) * STAGES / SHW != S) begin : g_cut
      assign lin[k] = r_d[S-1];
    end else begin : g_chain
      assign lin[k] = lout[k-1];
    end
    shift_level #(.W(W), .DIST(1 << k)) u_lvl (
      .data(lin[k]),
      .op  (s_op[S]),
      .en  (s_sh[S][k]),
      .q   (lout[k])
    );
    if (k == SHW - 1 || (k + 1) * STAGES / SHW != S) begin : g_last
      assign st[S] = lout[k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= 1'b0;
        r_d[i] <= '0;
        r_op[i] <= NOP;
        r_sh[i] <= '0;
        r_c[i] <= 1'b0;
      end
    end else if (!stall) begin
      r_z <= st[STAGES-1] == '0;
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= s_v[i];
        r_d[i] <= st[i];
        r_op[i] <= s_op[i];
        r_sh[i] <= s_sh[i];
        r_c[i] <= s_c[i];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_shift_unit.sv
// tb_pipelined_shift_unit: scoreboard bench over several width/stage configurations
module tb_pipelined_shift_unit;
  import shift_pkg::*;
  typedef struct {
    logic [63:0] r;
    logic [1:0]  f;
    int          cyc;
    int          st;
  } exp_t;
  localparam int NC = 7;
  logic clk = 1'b0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  always #5 clk = ~clk;
  function automatic void check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d: got %0h expected %0h", name, g, act, exp);
    end
  endfunction
  function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b, input logic [2:0] op,
                                output logic [63:0] r, output logic [1:0] f);
    logic [63:0] mask, a;
    logic c;
    int sh;
    mask = w == 64 ? '1 : (64'd1 << w) - 64'd1;
    a = a_in & mask;
    sh = int'(b % 64'(w));
    c = 1'b0;
    case (op)
      3'd1: begin r = (a << sh) & mask; if (sh != 0) c = a[w-sh]; end
      3'd2: begin r = a >> sh; if (sh != 0) c = a[sh-1]; end
      3'd3: begin
        r = a >> sh;
        if (a[w-1]) r = r | (mask & ~(mask >> sh));
        if (sh != 0) c = a[sh-1];
      end
      3'd4: begin r = ((a >> sh) | (a << (w - sh))) & mask; if (sh != 0) c = r[w-1]; end
      3'd5: begin r = ((a << sh) | (a >> (w - sh))) & mask; if (sh != 0) c = r[0]; end
      default: r = a;
    endcase
    f = {c, r == 64'd0};
  endfunction
  for (genvar g = 0; g < NC; g++) begin : cfg
    localparam int W = g == 0 ? 32 : g < 3 ? 8 : g < 5 ? 32 : 64;
    localparam int S = g == 0 ? 2 : g == 2 ? 3 : g == 4 ? 5 : g == 6 ? 6 : 1;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] out_result;
    shift_op_e in_op = NOP;
    logic [1:0] out_flag;
    exp_t q[$];
    exp_t e;
    logic [63:0] mr, pr;
    logic [1:0] mf, pf;
    logic held = 1'b0;
    logic running = 1'b0;
    int cyc = 0;
    int stalls = 0;
    pipelined_shift_unit #(.W(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_flag  (out_flag)
    );
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
      int t;
      in_valid = 1'b1;
      in_a = a[W-1:0];
      in_b = b[W-1:0];
      in_op = shift_op_e'(op);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 200);
      check("accept", g, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    endtask
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", g, 64'(out_valid), 64'd1);
          check("stall_result", g, 64'(out_result), pr);
          check("stall_flag", g, 64'(out_flag), 64'(pf));
        end
        check("in_ready", g, 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (out_valid && out_ready) begin
          check("output_expected", g, 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("result", g, 64'(out_result), e.r);
            check("flag", g, 64'(out_flag), 64'(e.f));
            if (e.st == stalls) check("latency", g, 64'(cyc - e.cyc), 64'(S));
          end
        end
        held = out_valid && !out_ready;
        pr = 64'(out_result);
        pf = out_flag;
        if (held) stalls++;
        if (in_valid && in_ready) begin
          model(W, 64'(in_a), 64'(in_b), in_op, mr, mf);
          q.push_back('{mr, mf, cyc, stalls});
        end
      end
      cyc++;
    end
    initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_valid", g, 64'(out_valid), 64'd0);
      check("reset_result", g, 64'(out_result), 64'd0);
      check("reset_flag", g, 64'(out_flag), 64'd0);
      check("reset_ready", g, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      send(64'h8000_0001, 64'd1, 3'd1);
      send(64'h8000_0000, 64'd31, 3'd3);
      send(64'h8000_0000, 64'd31, 3'd2);
      send(64'h1, 64'd1, 3'd2);
      send(64'h1, 64'd4, 3'd4);
      send(64'h1234_5678_9abc_def0, 64'd33, 3'd5);
      send(64'hF0, 64'd7, 3'd6);
      send(64'h5A, 64'd0, 3'd4);
      send(64'h80, 64'd0, 3'd1);
      in_valid = 1'b0;
      repeat (S + 2) @(posedge clk);
      #1 out_ready = 1'b0;
      fork
        begin
          for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 64'($urandom), 3'($urandom_range(1, 5)));
          in_valid = 1'b0;
        end
        begin
          int t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (!out_valid && t < 50);
          repeat (5) @(posedge clk);
          #1 out_ready = 1'b1;
        end
      join
      repeat (S + 4) @(posedge clk);
      #1;
      send({$urandom, $urandom}, 64'($urandom), 3'd1);
      send({$urandom, $urandom}, 64'($urandom), 3'd4);
      in_a = '1;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("midrst_valid", g, 64'(out_valid), 64'd0);
      check("midrst_result", g, 64'(out_result), 64'd0);
      check("midrst_flag", g, 64'(out_flag), 64'd0);
      @(posedge clk);
      #1 running = 1'b1;
      fork
        begin
          for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              in_valid = 1'b0;
              @(posedge clk);
              #1;
            end
            send({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
          end
          in_valid = 1'b0;
          running = 1'b0;
        end
        begin
          while (running) begin
            @(posedge clk);
            #1 out_ready = $urandom_range(0, 2) != 0;
          end
        end
      join
      out_ready = 1'b1;
      for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
      check("drain", g, 64'(q.size()), 64'd0);
      done_cnt++;
    end
  end
  initial begin
    for (int t = 0; t < 50000 && done_cnt < NC; t++) @(posedge clk);
    check("all_done", 0, 64'(done_cnt), 64'(NC));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
